fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Parametrised instruction-fetch front end that replaces the single-register PC update with a decoupled fetch stage for the pipelined core. It holds the fetch PC and reads instruction memory each cycle. Fetched {pc, instr} pairs are buffered in a FIFO and presented to the decode stage (ID) over a valid/ready handshake. It also resolves control-flow redirects (beq, bne, j/jal, jr) arriving from the execution stage (EXEC) and flushes wrong-path instructions.

Parameters:
ADDR_W, 32, PC and memory address width (must be ≥ 28 and ≤ 32)
DATA_W, 32, instruction width
FQ_DEPTH, 4, fetch queue entries (power of two, ≥ 2)
RESET_PC, 0, fetch PC after reset (word aligned)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch enable this cycle
imem_addr  out  ADDR_W  fetch address (equals fetch PC)
imem_rdata  in  DATA_W  instruction at imem_addr, combinational same-cycle read
dec_valid  out  1  queue head is valid
dec_instr  out  DATA_W  queue head instruction
dec_pc  out  ADDR_W  queue head PC
dec_ready  in  1  decode accepts head this cycle
redir_valid  in  1  EXEC presents a resolved control-flow instruction
redir_kind  in  2  00 beq, 01 bne, 10 j/jal, 11 jr
redir_zf  in  1  ALU zero flag for the branch
redir_pc  in  ADDR_W  PC of the control-flow instruction
redir_imm  in  ADDR_W  sign-extended 16-bit immediate
redir_addr26  in  26  jump target field
redir_reg  in  ADDR_W  register value for jr
fq_count  out  $clog2(FQ_DEPTH)+1  current queue occupancy
misalign_err  out  1  one-cycle pulse: jr target not word aligned
flush_count  out  16  saturating count of taken redirects

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC, queue empty, fq_count=0, dec_valid=0, misalign_err=0, flush_count=0. imem_req=0 while rst is high.
- dec_valid = (fq_count != 0). dec_instr and dec_pc come directly from the head entry. A pop occurs when dec_valid && dec_ready.
- Taken redirect:
  - beq is taken when redir_valid && redir_zf.
  - bne is taken when redir_valid && !redir_zf.
  - j and jr are always taken when redir_valid.
  - Not-taken beq/bne has no effect on any state.
- Redirect targets (all arithmetic modulo 2^ADDR_W):
  - beq/bne: redir_pc + 4 + (redir_imm << 2).
  - j: {(redir_pc+4)[ADDR_W-1:28], redir_addr26, 2'b00}.
  - jr: {redir_reg[ADDR_W-1:2], 2'b00}. If redir_reg[1:0] != 0, misalign_err pulses high for the cycle after the redirect.
- imem_req = !rst && !taken && (fq_count < FQ_DEPTH || pop).
- When imem_req is high, {fetch_pc, imem_rdata} is pushed at the clock edge and fetch_pc <= fetch_pc + 4. Fetch latency is one cycle: the entry is visible on dec_* in the cycle after the push.
- When taken: queue cleared (fq_count=0), fetch_pc <= target, no push, and any simultaneous pop is ignored because the entry is discarded. flush_count increments and saturates at 16'hFFFF.
- Full queue with simultaneous pop: push and pop both occur and fq_count is unchanged.
- Full queue with no pop: imem_req=0 and fetch_pc holds (stall).
- Empty queue with dec_ready high: no pop, and pointers do not move.
- fetch_pc wraps from 2^ADDR_W-4 to 0 without error.
- Asserting rst mid-flush or mid-stall returns every state element to its reset value on the next edge. redir_valid is ignored while rst is high.
- Pointer wrap-around in the queue is modulo FQ_DEPTH. The occupancy counter distinguishes full from empty.

Decomposition:
- Shared package fetch_pkg:
  - redirect kind constants KIND_BEQ=2'b00, KIND_BNE=2'b01, KIND_J=2'b10, KIND_JR=2'b11.
  - PC increment constant PC_STEP=4.
- Sub-module fetch_queue: synchronous FIFO, parametrised width ADDR_W+DATA_W and depth FQ_DEPTH. Ports: push, pop, flush, data in/out, count.
- Target computation and the taken decision stay in fetch_unit.

Test Plan:
- Reset then stream: rst=1 for 2 cycles, dec_ready=1, imem returns addr>>2. Expect dec_pc 0, 4, 8, ... with one entry per cycle after a 1-cycle latency, and dec_instr 0, 1, 2.
- Backpressure: dec_ready=0 for 10 cycles, FQ_DEPTH=4. Expect fq_count=4, imem_req=0 and fetch_pc=16 held. Release dec_ready: PCs 0, 4, 8, 12, 16 delivered in order with no loss or duplicate.
- Branch: beq with redir_pc=0x20, imm=0xFFFFFFFE, zf=1. Expect queue flushed, next dec_pc=0x1C and flush_count=1. The same with bne zf=1: no flush, stream continues.
- Jump: j with redir_pc=0xF0000010, addr26=0x0000040. Expect next dec_pc=0xF0000100. Also check pop and redirect in the same cycle: the popped entry is discarded.
- jr misaligned: redir_reg=0x00000106. Expect next dec_pc=0x104 and misalign_err high for exactly 1 cycle.
- Wrap and reset mid-stall: fetch from 0xFFFFFFF8 and expect dec_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Then assert rst with a full queue: the next cycle has fq_count=0, dec_valid=0 and fetch_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch front end: redirect kinds and PC stride.
package fetch_pkg;

    localparam logic [1:0] KIND_BEQ = 2'b00;
    localparam logic [1:0] KIND_BNE = 2'b01;
    localparam logic [1:0] KIND_J   = 2'b10;
    localparam logic [1:0] KIND_JR  = 2'b11;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one edge.
module fetch_queue #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates validity so stale words are never consumed.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: PC register, fetch queue towards decode, and redirect resolution from EXEC.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic [DATA_W-1:0]         imem_rdata,
    output logic                      dec_valid,
    output logic [DATA_W-1:0]         dec_instr,
    output logic [ADDR_W-1:0]         dec_pc,
    input  logic                      dec_ready,
    input  logic                      redir_valid,
    input  logic [1:0]                redir_kind,
    input  logic                      redir_zf,
    input  logic [ADDR_W-1:0]         redir_pc,
    input  logic [ADDR_W-1:0]         redir_imm,
    input  logic [25:0]               redir_addr26,
    input  logic [ADDR_W-1:0]         redir_reg,
    output logic [$clog2(FQ_DEPTH):0] fq_count,
    output logic                      misalign_err,
    output logic [15:0]               flush_count
);

    localparam int                CNT_W    = $clog2(FQ_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    // Bits above the 256 MB jump segment survive a j; the mask is empty when ADDR_W is 28.
    localparam logic [ADDR_W-1:0] SEG_MASK = ~ADDR_W'(32'h0FFF_FFFF);

    logic [ADDR_W-1:0]        fetch_pc;
    logic [ADDR_W-1:0]        pc_plus4;
    logic [ADDR_W-1:0]        target;
    logic                     kind_taken;
    logic                     taken;
    logic                     pop;
    logic                     jr_misaligned;
    logic [ADDR_W+DATA_W-1:0] head;

    assign pc_plus4      = redir_pc + STEP;
    assign jr_misaligned = (redir_reg[1:0] != 2'b00);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        kind_taken = 1'b0;
        target     = pc_plus4;
        case (redir_kind)
            KIND_BEQ: begin
                kind_taken = redir_zf;
                target     = pc_plus4 + (redir_imm << 2);
            end
            KIND_BNE: begin
                kind_taken = !redir_zf;
                target     = pc_plus4 + (redir_imm << 2);
            end
            KIND_J: begin
                kind_taken = 1'b1;
                target     = (pc_plus4 & SEG_MASK) | ADDR_W'({redir_addr26, 2'b00});
            end
            KIND_JR: begin
                kind_taken = 1'b1;
                target     = {redir_reg[ADDR_W-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    assign taken     = !rst && redir_valid && kind_taken;
    assign dec_valid = (fq_count != '0);
    assign pop       = dec_valid && dec_ready;
    assign imem_req  = !rst && !taken && ((fq_count < CNT_W'(FQ_DEPTH)) || pop);
    assign imem_addr = fetch_pc;
    assign dec_pc    = head[ADDR_W+DATA_W-1:DATA_W];
    assign dec_instr = head[DATA_W-1:0];

    // A taken redirect discards the head, so the pop is withheld in that cycle.
    fetch_queue #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (imem_req),
        .pop   (pop && !taken),
        .flush (taken),
        .wdata ({fetch_pc, imem_rdata}),
        .rdata (head),
        .count (fq_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            misalign_err <= 1'b0;
            flush_count  <= '0;
        end else begin
            misalign_err <= taken && (redir_kind == KIND_JR) && jr_misaligned;
            if (taken) begin
                fetch_pc <= target;
                if (flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + STEP;
            end
        end
    end

endmodule
